// File: rtl/eb_pkg.sv
// Shared types and helpers for the credit-based link transmitter.
package eb_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } eb_state_e;

    // Bits needed to hold a credit count in 0..credits inclusive.
    function automatic int unsigned cnt_width(input int unsigned credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/eb_credit_cnt.sv
// Saturating up/down credit counter. Resets full; an increment while full
// is dropped and latches the sticky overflow flag.
module eb_credit_cnt
    import eb_pkg::*;
#(
    parameter int unsigned Max = 16,
    parameter int unsigned W   = cnt_width(Max)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         full_o,
    output logic         ovf_o
);

    localparam logic [W-1:0] MaxVal = W'(Max);

    logic [W-1:0] cnt_q, cnt_d;
    logic         ovf_q, ovf_d;

    // Next count: simultaneous inc and dec cancel; saturate at both ends.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        case ({inc_i, dec_i})
            2'b10: begin
                if (cnt_q == MaxVal) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            2'b01: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Count and error registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= MaxVal;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign full_o = (cnt_q == MaxVal);
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/eb_credit_tx.sv
// Credit-based link transmitter: forwards upstream beats onto a registered
// link while far-end credits remain, with a flush/drain handshake.
// Optional statistics counters are built when EB_CREDIT_TX_STATS_EN is defined.
module eb_credit_tx
    import eb_pkg::*;
#(
    parameter int unsigned DWIDTH  = 32,
    parameter int unsigned CREDITS = 16
) (
    input  logic              clk,
    input  logic              rstf,
    input  logic [DWIDTH-1:0] t_data,
    input  logic              t_valid,
    output logic              t_ready,
    output logic [DWIDTH-1:0] l_data,
    output logic              l_valid,
    input  logic              l_credit,
    input  logic              flush,
    output logic              flush_done,
`ifdef EB_CREDIT_TX_STATS_EN
    output logic [31:0]       stat_beats,
    output logic [31:0]       stat_stall,
`endif
    output logic              cr_err
);

    localparam int unsigned CW = cnt_width(CREDITS);

    logic [CW-1:0] credit_cnt;
    logic          cnt_full;
    logic          xfer;

    eb_state_e         state_q, state_d;
    logic              l_valid_q, l_valid_d;
    logic [DWIDTH-1:0] l_data_q, l_data_d;
    logic              flush_done_q, flush_done_d;

    // Ready depends only on registered state; held low while in reset.
    assign t_ready = !rstf && (credit_cnt != '0) && (state_q == RUN);
    assign xfer    = t_valid && t_ready;

    eb_credit_cnt #(
        .Max (CREDITS),
        .W   (CW)
    ) u_credit_cnt (
        .clk_i  (clk),
        .rst_i  (rstf),
        .inc_i  (l_credit),
        .dec_i  (xfer),
        .cnt_o  (credit_cnt),
        .full_o (cnt_full),
        .ovf_o  (cr_err)
    );

    // Link datapath: capture the beat on a transfer, otherwise hold data.
    always_comb begin
        l_valid_d = xfer;
        l_data_d  = l_data_q;
        if (xfer) begin
            l_data_d = t_data;
        end
    end

    // Flush FSM: drain waits for every credit to come home, then pulses done.
    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        unique case (state_q)
            RUN: begin
                if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_full) begin
                    state_d      = DONE;
                    flush_done_d = 1'b1;
                end
            end
            DONE: begin
                if (!flush) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // State, link and pulse registers.
    always_ff @(posedge clk or posedge rstf) begin
        if (rstf) begin
            state_q      <= RUN;
            l_valid_q    <= 1'b0;
            l_data_q     <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            l_valid_q    <= l_valid_d;
            l_data_q     <= l_data_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign l_valid    = l_valid_q;
    assign l_data     = l_data_q;
    assign flush_done = flush_done_q;

`ifdef EB_CREDIT_TX_STATS_EN
    logic [31:0] stat_beats_q, stat_beats_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    // Free-running wrap-around counters of beats and upstream stalls.
    always_comb begin
        stat_beats_d = stat_beats_q + {31'b0, xfer};
        stat_stall_d = stat_stall_q
                     + {31'b0, (t_valid && !t_ready && (state_q == RUN))};
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge rstf) begin
        if (rstf) begin
            stat_beats_q <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_beats_q <= stat_beats_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_beats = stat_beats_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_eb_credit_tx.sv
// Bench for eb_credit_tx: instance 0 has CREDITS=4, instance 1 CREDITS=16.
// A rule-level model is compared every cycle; directed literals pin it.
module tb_eb_credit_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstf;
    logic [1:0]  tv, lc, fl;
    logic [31:0] td [2];

    logic        tr0, tr1, lv0, lv1, fd0, fd1, ce0, ce1;
    logic [31:0] ld0, ld1;
    logic [1:0]  tr, lv, fdn, ce;
    logic [31:0] ld [2];
`ifdef EB_CREDIT_TX_STATS_EN
    logic [31:0] sb0, ss0, sb1, ss1;
`endif

    assign tr    = {tr1, tr0};
    assign lv    = {lv1, lv0};
    assign fdn   = {fd1, fd0};
    assign ce    = {ce1, ce0};
    assign ld[0] = ld0;
    assign ld[1] = ld1;

    eb_credit_tx #(.DWIDTH(32), .CREDITS(4)) u_dut4 (
        .clk        (clk),
        .rstf       (rstf),
        .t_data     (td[0]),
        .t_valid    (tv[0]),
        .t_ready    (tr0),
        .l_data     (ld0),
        .l_valid    (lv0),
        .l_credit   (lc[0]),
        .flush      (fl[0]),
        .flush_done (fd0),
`ifdef EB_CREDIT_TX_STATS_EN
        .stat_beats (sb0),
        .stat_stall (ss0),
`endif
        .cr_err     (ce0)
    );

    eb_credit_tx #(.DWIDTH(32), .CREDITS(16)) u_dut16 (
        .clk        (clk),
        .rstf       (rstf),
        .t_data     (td[1]),
        .t_valid    (tv[1]),
        .t_ready    (tr1),
        .l_data     (ld1),
        .l_valid    (lv1),
        .l_credit   (lc[1]),
        .flush      (fl[1]),
        .flush_done (fd1),
`ifdef EB_CREDIT_TX_STATS_EN
        .stat_beats (sb1),
        .stat_stall (ss1),
`endif
        .cr_err     (ce1)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          cmax [2] = '{4, 16};
    int          m_cred [2];
    int          m_mode [2];   // 0 run, 1 drain, 2 done
    logic        m_lv [2];
    logic        m_fd [2];
    logic        m_err [2];
    logic [31:0] m_ld [2];
    logic [31:0] sbq [$];

    function automatic logic m_ready(input int i);
        return !rstf && (m_mode[i] == 0) && (m_cred[i] > 0);
    endfunction

    always @(posedge clk or posedge rstf) begin
        if (rstf) begin
            for (int i = 0; i < 2; i++) begin
                m_cred[i] <= cmax[i];
                m_mode[i] <= 0;
                m_lv[i]   <= 1'b0;
                m_ld[i]   <= '0;
                m_fd[i]   <= 1'b0;
                m_err[i]  <= 1'b0;
            end
            sbq.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic x;
                int   nc;
                int   nm;
                x  = tv[i] && m_ready(i);
                nc = m_cred[i] - (x ? 1 : 0) + (lc[i] ? 1 : 0);
                nm = m_mode[i];
                if (nc > cmax[i]) begin
                    nc = cmax[i];
                    m_err[i] <= 1'b1;
                end
                if (m_mode[i] == 0 && fl[i]) nm = 1;
                if (m_mode[i] == 1 && m_cred[i] == cmax[i]) nm = 2;
                if (m_mode[i] == 2 && !fl[i]) nm = 0;
                m_fd[i]   <= (m_mode[i] == 1) && (m_cred[i] == cmax[i]);
                m_cred[i] <= nc;
                m_mode[i] <= nm;
                m_lv[i]   <= x;
                if (x) m_ld[i] <= td[i];
                if (x && i == 1) sbq.push_back(td[i]);
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("t_ready%0d", i), 32'(tr[i]), 32'(m_ready(i)));
            chk($sformatf("l_valid%0d", i), 32'(lv[i]), 32'(m_lv[i]));
            chk($sformatf("l_data%0d", i), ld[i], m_ld[i]);
            chk($sformatf("flush_done%0d", i), 32'(fdn[i]), 32'(m_fd[i]));
            chk($sformatf("cr_err%0d", i), 32'(ce[i]), 32'(m_err[i]));
        end
        if (!rstf && lv[1]) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL order16: l_valid with no accepted beat at %0t", $time);
            end else begin
                chk("order16", ld[1], sbq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    logic        h_lv [0:14];
    logic        h_tr [0:14];
    logic [31:0] h_ld [0:14];
    logic        f_lv [0:12];
    logic        f_tr [0:12];
    logic        f_fd [0:12];
    logic [5:0]  pipe;

    initial begin
        int nb;
        int sent;
        int ret;
        int maxf;

        rstf = 1'b1;
        tv = '0; lc = '0; fl = '0;
        td[0] = '0; td[1] = '0;
        repeat (2) tick();
        chk("rst_t_ready", 32'(tr0), 32'd0);
        chk("rst_l_valid", 32'(lv0), 32'd0);
        chk("rst_cr_err", 32'(ce0), 32'd0);

        // Burst into 4 credits, then a single returned credit at cycle 10.
        rstf = 1'b0;
        #1;
        chk("ready_cycle0", 32'(tr0), 32'd1);
        for (int c = 0; c < 15; c++) begin
            if (c > 0) tick();
            h_lv[c] = lv0;
            h_tr[c] = tr0;
            h_ld[c] = ld0;
            tv[0] = 1'b1;
            td[0] = 32'hA0 + 32'(c);
            lc[0] = (c == 10);
        end
        tick();
        tv[0] = 1'b0;
        lc[0] = 1'b0;
        nb = 0;
        for (int c = 0; c < 15; c++) nb += int'(h_lv[c]);
        chk("burst_beats_total", 32'(nb), 32'd5);
        chk("burst_lv_c0", 32'(h_lv[0]), 32'd0);
        chk("burst_lv_c1", 32'(h_lv[1]), 32'd1);
        chk("burst_ld_c1", h_ld[1], 32'hA0);
        chk("burst_ld_c4", h_ld[4], 32'hA3);
        chk("burst_lv_c5", 32'(h_lv[5]), 32'd0);
        chk("burst_tr_c4", 32'(h_tr[4]), 32'd0);
        chk("credit_tr_c10", 32'(h_tr[10]), 32'd0);
        chk("credit_tr_c11", 32'(h_tr[11]), 32'd1);
        chk("credit_tr_c12", 32'(h_tr[12]), 32'd0);
        chk("credit_lv_c12", 32'(h_lv[12]), 32'd1);
        chk("credit_ld_c12", h_ld[12], 32'hAB);

        // Refill, send 3 beats, then flush and return credits one by one.
        lc[0] = 1'b1;
        repeat (4) tick();
        lc[0] = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tv[0] = 1'b1;
            td[0] = 32'hB0 + 32'(j);
            tick();
        end
        tv[0] = 1'b0;
        for (int j = 0; j < 13; j++) begin
            if (j > 0) tick();
            f_lv[j] = lv0;
            f_tr[j] = tr0;
            f_fd[j] = fd0;
            fl[0] = (j < 10);
            lc[0] = (j == 2 || j == 4 || j == 6);
            tv[0] = (j > 0 && j < 10);
            td[0] = 32'hC0 + 32'(j);
        end
        tick();
        fl[0] = 1'b0; lc[0] = 1'b0; tv[0] = 1'b0;
        nb = 0;
        for (int j = 1; j < 13; j++) nb += int'(f_lv[j]);
        chk("flush_no_beats", 32'(nb), 32'd0);
        chk("flush_last_beat", 32'(f_lv[0]), 32'd1);
        chk("flush_tr_j0", 32'(f_tr[0]), 32'd1);
        chk("flush_tr_j1", 32'(f_tr[1]), 32'd0);
        nb = 0;
        for (int j = 0; j < 13; j++) nb += int'(f_fd[j]);
        chk("flush_done_count", 32'(nb), 32'd1);
        chk("flush_done_j8", 32'(f_fd[8]), 32'd1);
        chk("flush_tr_j10", 32'(f_tr[10]), 32'd0);
        chk("flush_tr_j11", 32'(f_tr[11]), 32'd1);

        // Overflow straight after reset; count must still allow 4 beats.
        rstf = 1'b1;
        tick();
        rstf = 1'b0;
        lc[0] = 1'b1;
        tick();
        lc[0] = 1'b0;
        chk("ovf_cr_err", 32'(ce0), 32'd1);
        nb = 0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) tick();
            nb += int'(lv0);
            tv[0] = 1'b1;
            td[0] = 32'hD0 + 32'(c);
        end
        tv[0] = 1'b0;
        tick();
        nb += int'(lv0);
        chk("ovf_beats", 32'(nb), 32'd4);
        chk("ovf_sticky", 32'(ce0), 32'd1);

        // Reset while a handshake is pending: beat must never appear.
        lc[0] = 1'b1;
        repeat (2) tick();
        lc[0] = 1'b0;
        tv[0] = 1'b1;
        td[0] = 32'hE5;
        #1;
        rstf = 1'b1;
        #1;
        chk("mid_rst_t_ready", 32'(tr0), 32'd0);
        chk("mid_rst_l_valid", 32'(lv0), 32'd0);
        chk("mid_rst_l_data", ld0, 32'd0);
        chk("mid_rst_flush_done", 32'(fd0), 32'd0);
        chk("mid_rst_cr_err", 32'(ce0), 32'd0);
        chk("mid_rst_t_ready16", 32'(tr1), 32'd0);
        tick();
        tv[0] = 1'b0;
        rstf = 1'b0;
        #1;
        chk("post_rst_t_ready", 32'(tr0), 32'd1);
        tick();
        chk("post_rst_discard", 32'(lv0), 32'd0);

        // CREDITS=16: random valid, each credit returned 5 cycles after its beat.
        pipe = '0;
        sent = 0;
        ret  = 0;
        maxf = 0;
        for (int c = 0; c < 320; c++) begin
            tick();
            pipe  = {pipe[4:0], lv1};
            if (lv1) sent++;
            lc[1] = pipe[5];
            if (lc[1]) ret++;
            if (sent - ret > maxf) maxf = sent - ret;
            tv[1] = (c < 290) ? 1'($urandom_range(0, 1)) : 1'b0;
            td[1] = $urandom;
        end
        lc[1] = 1'b0;
        tv[1] = 1'b0;
        tick();
        chk("c16_inflight_le_16", 32'(maxf <= 16), 32'd1);
        chk("c16_beats_seen", 32'(sent > 100), 32'd1);
        chk("c16_all_returned", 32'(sent), 32'(ret));
        chk("c16_cr_err", 32'(ce1), 32'd0);
        chk("c16_scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
